raster_to_block: RTL and testbench
==================================

# raster_to_block

Raster-to-block formatter for the front of the JPEG encoder pipeline. It accepts image lines in raster order, eight pixels per beat, and buffers one 8-line stripe while the previous stripe is read out. It emits 8x8 blocks row by row with sob/eob/sof framing, in the same row-stream format that the downstream matrix buffer and DCT stages consume. Storage is a double-buffered stripe memory, so input at one beat per cycle is sustained without stalls.

## Interface
- W_PIX, 8, bits per pixel
- MAX_BLK_W, 80, maximum image width in 8-pixel blocks (e.g. 640 px)
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- cfg_blk_w  input  $clog2(MAX_BLK_W+1)  image width in blocks; sampled on accepted in_sof
- cfg_blk_h  input  16  image height in blocks (stripes); sampled on accepted in_sof
- in_valid  input  1  input beat valid; no backpressure
- in_data  input  [7:0][W_PIX-1:0]  8 horizontally adjacent pixels; element 0 is leftmost
- in_sof  input  1  first beat of frame (line 0, word 0), qualified by in_valid
- out_valid  output  1  output row valid
- out_data  output  [7:0][W_PIX-1:0]  one 8-pixel block row
- out_sob  output  1  row 0 of a block
- out_eob  output  1  row 7 of a block
- out_sof  output  1  row 0 of block 0 of stripe 0 of a frame
- overflow  output  1  sticky; a stripe completed while readout was still pending

## Operation
- Clamping: cfg_blk_w of 0 is treated as 1; values above MAX_BLK_W are treated as MAX_BLK_W. cfg_blk_h of 0 is treated as 1.
- Writer FSM states: WAIT_SOF (reset state) and FILL.
  - Counters: line (0..7), x (0..blk_w-1), stripe (0..blk_h-1), plus write-buffer select wsel.
- Writer in WAIT_SOF:
  - Beats without in_sof are dropped.
  - An accepted in_sof beat latches the config, writes buf[wsel][0][0], sets x=1, and enters FILL.
- Writer in FILL:
  - Each accepted beat writes buf[wsel][line][x], then increments x. At x wrap, line increments.
  - When the beat at line 7, x = blk_w-1 is accepted, the stripe is complete.
  - If the reader is free: wsel toggles and stripe increments. After stripe blk_h-1 completes, the writer returns to WAIT_SOF.
  - If the reader is busy (overflow): the stripe is discarded, overflow is set, and wsel is unchanged. The writer restarts at line 0, x 0, and the stripe counter is unchanged.
- in_sof while in FILL: resynchronises. The partial stripe is discarded, the config is re-latched, the beat is written at line 0, x 0 of the current wsel, and stripe resets to 0.
- Reader FSM states: IDLE and READ.
  - On stripe completion, the reader latches rsel = wsel (before the toggle) and first = (stripe == 0).
  - It issues reads in block order: for x = 0..blk_w-1, for row = 0..7, read buf[rsel][row][x], one read per cycle, 8*blk_w reads total.
- Output row flags: out_sob when row==0; out_eob when row==7; out_sof when row==0, x==0 and first.
- Reader "busy" means at least one read remains after the current cycle. A completion in the same cycle as the final read is not an overflow: the reader chains directly into the new stripe with no bubble.
- The writer never writes buf[rsel] while reading is pending. This holds by construction, since writes are limited to wsel != rsel.

## Timing
- Reset values: out_valid, out_data, out_sob, out_eob, out_sof and overflow are all 0. Writer is in WAIT_SOF, reader in IDLE, wsel=0.
- Latency: if the completing beat is accepted in cycle N, the first read is issued in N+1 and out_valid with row 0 is registered at N+2.
- out_valid then stays high for exactly 8*blk_w consecutive cycles.
- With back-to-back stripes at full input rate, out_valid is continuous across stripes.
- All outputs are registered, aligned with the RAM read data, and change only on clk.
- Reset mid-operation discards all buffered data. overflow clears only on reset.
- Input gaps (in_valid=0) only pause the writer. The reader is unaffected.

## Structure
- Shared package jpeg_pkg holds:
  - BLK_DIM = 8
  - typedef pix_row_t = logic [7:0][W_PIX-1:0]
- Sub-module stripe_ram: simple dual-port RAM with 2*8*MAX_BLK_W words of 8*W_PIX bits.
  - One write port, one read port with a registered read (1-cycle latency).
  - Address = {sel, line, x}.
- The top level holds the writer FSM, reader FSM, address generation, and the flag pipeline register.

## Test plan
- Small frame: blk_w=2, blk_h=1, 16 continuous beats with pixel = {line, x, col} after sof.
  - Expect outputs at cycles 18..33: block 0 rows 0..7, then block 1 rows 0..7.
  - Flags: sob on rows 0, eob on rows 7, sof on the first row only.
- Two-stripe frame: blk_w=3, blk_h=2, 48 continuous beats.
  - out_valid continuous for 48 cycles.
  - sof asserted once; stripe 1 block 0 row 0 carries sob but not sof.
- Gappy input: blk_w=2, blk_h=1 with in_valid toggling every cycle.
  - Output identical to the first test; out_valid begins 2 cycles after the 16th accepted beat.
- Resync: in_sof at line 3 mid-stripe, then a full 8-line stripe.
  - Only the new stripe is emitted; no overflow.
- Overflow: blk_w=4 stripe completes, then in_sof with cfg_blk_w=1 and 8 beats while readout is pending.
  - overflow=1 and stays 1; the first stripe's 32 rows are intact; the short stripe is not emitted.
- Reset mid-readout: assert rst_n=0 during out_valid.
  - All outputs go to 0 immediately. After release, beats without in_sof are dropped.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG encoder front end.
//   BLK_DIM    : block edge length in pixels
//   PIX_BITS   : default pixel width
//   pix_row_t  : one 8-pixel row, element 0 is the leftmost pixel
//   wr_state_e : raster writer states
//   rd_state_e : block reader states
package jpeg_pkg;

  localparam int unsigned BLK_DIM  = 8;
  localparam int unsigned PIX_BITS = 8;

  typedef logic [BLK_DIM-1:0][PIX_BITS-1:0] pix_row_t;

  typedef enum logic {
    WR_WAIT_SOF,
    WR_FILL
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_e;

endpackage

// File: rtl/raster_to_block_stripe_ram.sv
// Simple dual-port stripe memory with a registered read port.
//   clk_i   : clock
//   rst_ni  : async active-low reset (clears the read data register only)
//   we_i    : write enable
//   waddr_i : write address {sel, line, x}
//   wdata_i : write data
//   re_i    : read enable
//   raddr_i : read address {sel, row, x}
//   rdata_o : read data, valid one cycle after re_i
module stripe_ram #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  // Depth follows the concatenated {sel, line, x} address, so x is padded
  // up to a power of two.
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/raster_to_block.sv
// Raster-to-block formatter. Buffers one 8-line stripe of raster input while
// the previous stripe is read out as 8x8 blocks, row by row.
//   clk, rst_n          : clock, async active-low reset
//   cfg_blk_w/cfg_blk_h : image size in blocks, latched on accepted in_sof
//   in_valid/in_sof     : input beat qualifiers (no backpressure)
//   in_data             : 8 horizontally adjacent pixels
//   out_valid/out_data  : one block row per cycle
//   out_sob/out_eob     : block row 0 / row 7
//   out_sof             : row 0 of block 0 of stripe 0
//   overflow            : sticky, a stripe completed while readout pending
module raster_to_block
  import jpeg_pkg::*;
#(
  parameter int unsigned W_PIX     = 8,
  parameter int unsigned MAX_BLK_W = 80,
  localparam int unsigned BW = $clog2(MAX_BLK_W + 1),
  localparam int unsigned XW = (MAX_BLK_W > 1) ? $clog2(MAX_BLK_W) : 1,
  localparam int unsigned AW = 1 + 3 + XW
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [BW-1:0]                   cfg_blk_w,
  input  logic [15:0]                     cfg_blk_h,
  input  logic                            in_valid,
  input  logic [BLK_DIM-1:0][W_PIX-1:0]   in_data,
  input  logic                            in_sof,
  output logic                            out_valid,
  output logic [BLK_DIM-1:0][W_PIX-1:0]   out_data,
  output logic                            out_sob,
  output logic                            out_eob,
  output logic                            out_sof,
  output logic                            overflow
);

  function automatic logic [BW-1:0] clamp_w(input logic [BW-1:0] w);
    if (w == '0)                return BW'(1);
    else if (w > BW'(MAX_BLK_W)) return BW'(MAX_BLK_W);
    else                        return w;
  endfunction

  // Writer state
  wr_state_e     wr_state_q, wr_state_d;
  logic [2:0]    line_q, line_d;
  logic [XW-1:0] x_q, x_d;
  logic [15:0]   stripe_q, stripe_d;
  logic          wsel_q, wsel_d;
  logic [BW-1:0] blk_w_q, blk_w_d;
  logic [15:0]   blk_h_q, blk_h_d;
  logic          ovf_q, ovf_d;

  // Reader state
  rd_state_e     rd_state_q, rd_state_d;
  logic [XW-1:0] rx_q, rx_d;
  logic [2:0]    rrow_q, rrow_d;
  logic          rsel_q, rsel_d;
  logic          first_q, first_d;
  logic [BW-1:0] rblk_w_q, rblk_w_d;

  // Output flag pipeline, aligned with the RAM read register
  logic vld_q, vld_d, sob_q, sob_d, eob_q, eob_d, sof_q, sof_d;

  logic          we, re, rd_start, rd_last, rd_busy;
  logic [AW-1:0] waddr, raddr;
  logic [2:0]    wr_line;
  logic [XW-1:0] wr_x;
  logic [BW-1:0] wr_w;
  logic [BLK_DIM*W_PIX-1:0] rdata;

  assign rd_last = (rrow_q == 3'd7) && (BW'(rx_q) == rblk_w_q - BW'(1));
  // Busy only if reads remain after this cycle; the final read cycle lets a
  // new stripe chain in with no bubble.
  assign rd_busy = (rd_state_q == RD_READ) && !rd_last;

  always_comb begin
    wr_state_d = wr_state_q;
    line_d     = line_q;
    x_d        = x_q;
    stripe_d   = stripe_q;
    wsel_d     = wsel_q;
    blk_w_d    = blk_w_q;
    blk_h_d    = blk_h_q;
    ovf_d      = ovf_q;
    we         = 1'b0;
    rd_start   = 1'b0;
    wr_line    = line_q;
    wr_x       = x_q;
    wr_w       = blk_w_q;

    // in_sof restarts the frame from any state; the beat then advances the
    // position exactly like a normal beat at line 0, x 0.
    if (in_valid && in_sof) begin
      blk_w_d    = clamp_w(cfg_blk_w);
      blk_h_d    = (cfg_blk_h == '0) ? 16'd1 : cfg_blk_h;
      stripe_d   = '0;
      wr_state_d = WR_FILL;
      wr_line    = '0;
      wr_x       = '0;
      wr_w       = blk_w_d;
    end

    if (in_valid && (in_sof || (wr_state_q == WR_FILL))) begin
      we = 1'b1;
      if (BW'(wr_x) == wr_w - BW'(1)) begin
        x_d = '0;
        if (wr_line == 3'd7) begin
          line_d = '0;
          if (rd_busy) begin
            ovf_d = 1'b1;
          end else begin
            rd_start = 1'b1;
            wsel_d   = ~wsel_q;
            if (stripe_q == blk_h_q - 16'd1) begin
              stripe_d   = '0;
              wr_state_d = WR_WAIT_SOF;
            end else begin
              stripe_d = stripe_q + 16'd1;
            end
          end
        end else begin
          line_d = wr_line + 3'd1;
        end
      end else begin
        x_d    = wr_x + 1'b1;
        line_d = wr_line;
      end
    end
  end

  assign waddr = {wsel_q, wr_line, wr_x};

  always_comb begin
    rd_state_d = rd_state_q;
    rx_d       = rx_q;
    rrow_d     = rrow_q;
    rsel_d     = rsel_q;
    first_d    = first_q;
    rblk_w_d   = rblk_w_q;
    re         = 1'b0;
    vld_d      = 1'b0;
    sob_d      = 1'b0;
    eob_d      = 1'b0;
    sof_d      = 1'b0;

    if (rd_state_q == RD_READ) begin
      re    = 1'b1;
      vld_d = 1'b1;
      sob_d = (rrow_q == 3'd0);
      eob_d = (rrow_q == 3'd7);
      sof_d = (rrow_q == 3'd0) && (rx_q == '0) && first_q;
      if (rd_last) begin
        rd_state_d = RD_IDLE;
      end else if (rrow_q == 3'd7) begin
        rrow_d = '0;
        rx_d   = rx_q + 1'b1;
      end else begin
        rrow_d = rrow_q + 3'd1;
      end
    end

    if (rd_start) begin
      rd_state_d = RD_READ;
      rx_d       = '0;
      rrow_d     = '0;
      rsel_d     = wsel_q;
      first_d    = (stripe_q == '0);
      rblk_w_d   = blk_w_q;
    end
  end

  assign raddr = {rsel_q, rrow_q, rx_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= WR_WAIT_SOF;
      line_q     <= '0;
      x_q        <= '0;
      stripe_q   <= '0;
      wsel_q     <= 1'b0;
      blk_w_q    <= BW'(1);
      blk_h_q    <= 16'd1;
      ovf_q      <= 1'b0;
      rd_state_q <= RD_IDLE;
      rx_q       <= '0;
      rrow_q     <= '0;
      rsel_q     <= 1'b0;
      first_q    <= 1'b0;
      rblk_w_q   <= BW'(1);
      vld_q      <= 1'b0;
      sob_q      <= 1'b0;
      eob_q      <= 1'b0;
      sof_q      <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      line_q     <= line_d;
      x_q        <= x_d;
      stripe_q   <= stripe_d;
      wsel_q     <= wsel_d;
      blk_w_q    <= blk_w_d;
      blk_h_q    <= blk_h_d;
      ovf_q      <= ovf_d;
      rd_state_q <= rd_state_d;
      rx_q       <= rx_d;
      rrow_q     <= rrow_d;
      rsel_q     <= rsel_d;
      first_q    <= first_d;
      rblk_w_q   <= rblk_w_d;
      vld_q      <= vld_d;
      sob_q      <= sob_d;
      eob_q      <= eob_d;
      sof_q      <= sof_d;
    end
  end

  stripe_ram #(
    .AW(AW),
    .DW(BLK_DIM * W_PIX)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (in_data),
    .re_i    (re),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign out_valid = vld_q;
  assign out_data  = rdata;
  assign out_sob   = sob_q;
  assign out_eob   = eob_q;
  assign out_sof   = sof_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_raster_to_block.sv
module tb_raster_to_block;
  import jpeg_pkg::*;

  localparam int unsigned MAXW = 80;
  localparam int unsigned BW   = $clog2(MAXW + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [BW-1:0]  cfg_blk_w;
  logic [15:0]    cfg_blk_h;
  logic           in_valid, in_sof;
  pix_row_t       in_data;
  logic           out_valid, out_sob, out_eob, out_sof, overflow;
  pix_row_t       out_data;

  raster_to_block #(.W_PIX(8), .MAX_BLK_W(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_blk_w(cfg_blk_w), .cfg_blk_h(cfg_blk_h),
    .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_valid(out_valid), .out_data(out_data), .out_sob(out_sob),
    .out_eob(out_eob), .out_sof(out_sof), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    pix_row_t    data;
    logic        sob, eob, sof;
    int unsigned cyc;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference model: frame position plus one captured stripe image
  pix_row_t    img [8][MAXW];
  bit          m_active, m_ovf;
  int          m_w, m_h, m_line, m_x, m_stripe;
  int unsigned m_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int clamp_w(input int w);
    return (w == 0) ? 1 : ((w > int'(MAXW)) ? int'(MAXW) : w);
  endfunction

  function automatic int clamp_h(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  task automatic model_reset();
    expq.delete();
    m_active = 0; m_ovf = 0; m_last = 0;
    m_line = 0; m_x = 0; m_stripe = 0; m_w = 1; m_h = 1;
  endtask

  // A finished stripe is emitted block by block, row by row, one row per
  // cycle starting the cycle after completion, unless a readout is pending.
  task automatic model_complete(input int unsigned e);
    exp_t it;
    if (e >= m_last) begin
      for (int x = 0; x < m_w; x++) begin
        for (int r = 0; r < 8; r++) begin
          it.data = img[r][x];
          it.sob  = (r == 0);
          it.eob  = (r == 7);
          it.sof  = (r == 0) && (x == 0) && (m_stripe == 0);
          it.cyc  = e + 1 + int'(x * 8 + r);
          expq.push_back(it);
        end
      end
      m_last = e + int'(8 * m_w);
      m_stripe++;
      if (m_stripe == m_h) begin
        m_active = 0;
        m_stripe = 0;
      end
    end else begin
      m_ovf = 1;
    end
  endtask

  task automatic model_beat(input bit v, input bit s, input pix_row_t d, input int cw, input int ch);
    if (!v) return;
    if (s) begin
      m_w = clamp_w(cw); m_h = clamp_h(ch);
      m_active = 1; m_line = 0; m_x = 0; m_stripe = 0;
    end
    if (!m_active) return;
    img[m_line][m_x] = d;
    if (m_x == m_w - 1) begin
      m_x = 0;
      if (m_line == 7) begin
        m_line = 0;
        model_complete(cyc);
      end else begin
        m_line++;
      end
    end else begin
      m_x++;
    end
  endtask

  task automatic beat(input bit v, input bit s, input pix_row_t d);
    int cw, ch;
    cw = int'(cfg_blk_w);
    ch = int'(cfg_blk_h);
    in_valid = v; in_sof = s; in_data = d;
    @(posedge clk); #1;
    model_beat(v, s, d, cw, ch);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, '0);
  endtask

  function automatic pix_row_t pat_row(input int l, input int x);
    pix_row_t r;
    for (int c = 0; c < 8; c++) r[c] = {3'(l), 2'(x), 3'(c)};
    return r;
  endfunction

  function automatic pix_row_t rnd_row();
    pix_row_t r;
    r = {$urandom, $urandom};
    return r;
  endfunction

  // gap < 0: alternate valid/idle; otherwise percent chance of idle before each beat
  task automatic send_frame(input int w, input int h, input int gap, input bit pat);
    int cw, ch;
    bit first;
    cfg_blk_w = BW'(w);
    cfg_blk_h = 16'(h);
    cw = clamp_w(w);
    ch = clamp_h(h);
    first = 1;
    for (int s = 0; s < ch; s++)
      for (int l = 0; l < 8; l++)
        for (int x = 0; x < cw; x++) begin
          if (gap > 0) while (int'($urandom_range(99)) < gap) idle(1);
          beat(1'b1, first, pat ? pat_row(l, x) : rnd_row());
          if (first) begin
            // config must only matter at the sof beat
            cfg_blk_w = BW'($urandom);
            cfg_blk_h = 16'($urandom);
            first = 0;
          end
          if (gap < 0) idle(1);
        end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) chk("overflow", 64'(overflow), 64'(m_ovf));
    if (out_valid) begin
      if (expq.size() == 0) begin
        chk("unexpected_row", 64'(out_valid), 64'd0);
      end else begin
        mon_e = expq.pop_front();
        chk("row_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("row_data", out_data, mon_e.data);
        chk("row_sob", 64'(out_sob), 64'(mon_e.sob));
        chk("row_eob", 64'(out_eob), 64'(mon_e.eob));
        chk("row_sof", 64'(out_sof), 64'(mon_e.sof));
      end
    end else if (expq.size() != 0 && expq[0].cyc <= cyc) begin
      mon_e = expq.pop_front();
      chk("missing_row", 64'(out_valid), 64'd1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wl [7];
    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    cfg_blk_w = '0; cfg_blk_h = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_flags", {61'd0, out_sob, out_eob, out_sof}, 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;

    // beats without sof are dropped
    for (int i = 0; i < 10; i++) beat(1'b1, 1'b0, rnd_row());
    // small frame with labelled pixels
    send_frame(2, 1, 0, 1);
    idle(20);
    // two stripes, continuous output across them
    send_frame(3, 2, 0, 0);
    idle(30);
    // gappy input
    send_frame(2, 1, -1, 1);
    idle(20);
    // resync at line 3 of a partial stripe
    cfg_blk_w = BW'(2); cfg_blk_h = 16'd1;
    beat(1'b1, 1'b1, rnd_row());
    for (int i = 0; i < 6; i++) beat(1'b1, 1'b0, rnd_row());
    send_frame(2, 1, 0, 0);
    idle(20);
    // overflow: short stripe completes while the wide one is read out
    send_frame(4, 1, 0, 0);
    send_frame(1, 1, 0, 0);
    idle(40);
    chk("overflow_sticky", 64'(overflow), 64'd1);
    // reset during readout
    send_frame(2, 1, 0, 0);
    idle(5);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    chk("mid_rst_flags", {61'd0, out_sob, out_eob, out_sof}, 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) beat(1'b1, 1'b0, rnd_row());
    idle(30);
    // randomized frames, including clamped sizes
    wl = '{0, 1, 2, 5, 3, 100, 7};
    for (int f = 0; f < 7; f++) begin
      send_frame(wl[f], int'($urandom_range(0, 3)), int'($urandom_range(0, 30)), 0);
      if ($urandom_range(1) == 1) begin
        for (int i = 0; i < int'($urandom_range(1, 6)); i++) beat(1'b1, 1'b0, rnd_row());
      end
    end
    for (int i = 0; i < 3000 && expq.size() != 0; i++) idle(1);
    idle(5);
    chk("drain_empty", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
